// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : DEPTH-entry transmit FIFO with a registered hold stage that
//            presents words to the UART transmitter on a valid/ready pair.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [DATA_WIDTH-1:0]      tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic                    r_overflow;
    logic                    w_full;
    logic                    w_nonempty;
    logic                    w_push;
    logic                    w_pop;

    assign w_full     = (r_count == c_full_count);
    assign w_nonempty = (r_count != '0);
    // Push is gated by registered full only, so a same-cycle pop never frees a slot.
    assign w_push     = wr_valid && !w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (tx_ready) begin
                    if (w_nonempty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is intentionally left unreset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign wr_ready = !w_full;
    assign tx_data  = r_hold;
    assign tx_valid = (r_state == S_VALID);
    assign count    = r_count;
    assign empty    = !w_nonempty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (DEPTH=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;

    logic                    clk;
    logic                    rst_n;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [4:0]              count;
    logic                    empty;
    logic                    full;
    logic                    overflow;

    int n_checks;
    int n_fail;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        int cyc;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data",  32'(tx_data),  0);
        check("rst_count",    32'(count),    0);
        check("rst_empty",    32'(empty),    1);
        check("rst_full",     32'(full),     0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Single word: one-cycle latency, held until tx_ready
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("single_count_after_push", 32'(count),    1);
        check("single_valid_n",          32'(tx_valid), 0);
        tick();
        check("single_valid_n1", 32'(tx_valid), 1);
        check("single_data_n1",  32'(tx_data),  32'h A5);
        check("single_count_n1", 32'(count),    0);
        for (int i = 0; i < 9; i++) tick();
        check("single_data_held",  32'(tx_data),  32'hA5);
        check("single_valid_held", 32'(tx_valid), 1);
        pulse_ready();
        check("single_valid_done", 32'(tx_valid), 0);
        check("single_empty_done", 32'(empty),    1);

        // Burst of 5: hold=01, four queued
        for (int i = 1; i <= 5; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        check("burst_count", 32'(count),   4);
        check("burst_first", 32'(tx_data), 32'h01);

        // Simultaneous push and pop keeps count at 4
        wr_data  = 8'h06;
        wr_valid = 1'b1;
        tx_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        check("simul_count", 32'(count),   4);
        check("simul_data",  32'(tx_data), 32'h02);

        for (int k = 2; k <= 6; k++) begin
            check("burst_valid",  32'(tx_valid), 1);
            check("burst_data",   32'(tx_data),  32'(k));
            check("burst_count_dec", 32'(count), 32'(6 - k));
            tick();
            check("burst_data_stable", 32'(tx_data), 32'(k));
            pulse_ready();
        end
        check("burst_valid_end", 32'(tx_valid), 0);

        // Spurious tx_ready while idle
        pulse_ready();
        tick();
        check("spur_valid", 32'(tx_valid), 0);
        check("spur_count", 32'(count),    0);
        check("spur_empty", 32'(empty),    1);

        // Fill: 17 accepted (16 stored + hold), 18th dropped
        for (int i = 0; i < 17; i++) begin
            wr_data  = 8'(8'h10 + i);
            wr_valid = 1'b1;
            tick();
        end
        check("fill_full",     32'(full),     1);
        check("fill_wr_ready", 32'(wr_ready), 0);
        check("fill_count",    32'(count),    16);
        check("fill_no_ovf",   32'(overflow), 0);
        wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        check("ovf_set",   32'(overflow), 1);
        check("ovf_count", 32'(count),    16);
        for (int k = 0; k < 17; k++) begin
            check("drain_valid", 32'(tx_valid), 1);
            check("drain_data",  32'(tx_data),  32'(8'h10 + k));
            pulse_ready();
        end
        check("drain_valid_end", 32'(tx_valid), 0);
        check("ovf_sticky",      32'(overflow), 1);

        // Stream 40 words through the ring (pointer wrap)
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 40 && cyc < 2000) begin
            wr_valid = (sent < 40) && wr_ready;
            wr_data  = 8'(8'h40 + sent);
            tx_ready = tx_valid && (cyc % 3 == 0);
            if (tx_ready) begin
                check("wrap_data", 32'(tx_data), 32'(8'h40 + got));
                got++;
            end
            if (wr_valid) sent++;
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        check("wrap_received", 32'(got), 40);

        // Asynchronous reset mid-frame with 3 words queued behind hold
        for (int i = 0; i < 4; i++) begin
            wr_data  = 8'(8'hC0 + i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        check("pre_rst_count", 32'(count),    3);
        check("pre_rst_valid", 32'(tx_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 0);
        check("arst_tx_data",  32'(tx_data),  0);
        check("arst_count",    32'(count),    0);
        check("arst_empty",    32'(empty),    1);
        check("arst_wr_ready", 32'(wr_ready), 1);
        check("arst_overflow", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_tx_valid", 32'(tx_valid), 0);
        check("post_rst_count",    32'(count),    0);
        check("post_rst_empty",    32'(empty),    1);
        check("post_rst_wr_ready", 32'(wr_ready), 1);
        check("post_rst_overflow", 32'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts bytes from the system side with a ready/valid write port and stores them in a DEPTH-entry FIFO. It presents them one at a time to the transmitter on a valid/ready pair that matches the transmitter's contract: data held stable from `tx_valid` rise until the single-cycle `tx_ready` completion pulse. It lets software or a producer burst several bytes without waiting for the serial line.

## Interface
- `DATA_WIDTH`, 8, word width; equals transmitter `data_width`
- `DEPTH`, 16, FIFO storage entries; power of two, ≥2
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_data`  in  DATA_WIDTH  word to enqueue
- `wr_valid`  in  1  producer offers `wr_data`
- `wr_ready`  out  1  FIFO not full; a write is accepted on `wr_valid && wr_ready`
- `tx_data`  out  DATA_WIDTH  word being transmitted; drives transmitter `data_in`
- `tx_valid`  out  1  `tx_data` is valid; drives transmitter `data_valid`
- `tx_ready`  in  1  one-cycle pulse from transmitter `data_ready`: word finished
- `count`  out  $clog2(DEPTH)+1  entries in storage, excluding the hold register
- `empty`  out  1  `count==0`
- `full`  out  1  `count==DEPTH`
- `overflow`  out  1  sticky: a write was attempted while full

## Operation
- Storage: DEPTH×DATA_WIDTH array, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0. The `count` register is updated +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- Hold register `hold` drives `tx_data` directly from a flop, never from the array read path combinationally.
- FSM, 2 states:
  - S_IDLE (`tx_valid=0`): if `count!=0`, load `hold<=mem[rd_ptr]`, `rd_ptr++`, go to S_VALID.
  - S_VALID (`tx_valid=1`): `hold` is frozen until `tx_ready`. On `tx_ready`:
    - if `count!=0`, load the next word, `rd_ptr++`, and stay in S_VALID (back-to-back).
    - otherwise go to S_IDLE.
- `tx_ready` in S_IDLE is ignored with no state change.
- Push (`wr_valid && !full`) and pop (FSM load) in the same cycle are both performed.
- When full, a push is not performed even if a pop occurs that cycle, because `wr_ready` reflects registered `full`.
- Write with `wr_valid && full`: the data is dropped, pointers are unchanged, and `overflow<=1`. `overflow` clears only on reset.
- Reset (`rst_n=0`, any time, including mid-transmission) applies immediately:
  - S_IDLE, pointers 0, `count=0`, `hold=0`, `overflow=0`.
  - Outputs: `tx_valid=0`, `tx_data=0`, `wr_ready=1`, `empty=1`, `full=0`.
  - Array contents are not reset and are don't-care.
  - The transmitter is reset by the same reset and is not otherwise resynchronised.

## Timing
- All outputs are registered or decoded only from registers (`wr_ready=!full`, `empty`, `full` from `count`).
- Write-to-transmit latency into an empty block: a push at edge N gives `count=1` after N. The load happens at edge N+1, so `tx_valid=1` and `tx_data` are valid in cycle N+1.
- `tx_data` is stable for every cycle `tx_valid=1` until the edge at which `tx_ready=1` is sampled.
- After a `tx_ready` pulse sampled at edge M:
  - if `count!=0`, the next `tx_data` appears in cycle M+1 with `tx_valid` staying 1;
  - otherwise `tx_valid=0` in cycle M+1.
- The transmitter re-samples `data_valid` in that cycle M+1, so no word is sent twice.
- Throughput: one word per transmitter frame; the FIFO adds no idle cycles between frames.

## Test plan
- Reset values: assert `rst_n=0` mid-frame with 3 words queued → `tx_valid=0`, `count=0`, `empty=1`, `wr_ready=1`, `overflow=0` immediately and after release.
- Single word: push 8'hA5 at edge N → `tx_valid=1`, `tx_data=8'hA5` in cycle N+1 and held until the model pulses `tx_ready` 10 bit-times later → `tx_valid=0` the next cycle; exactly one frame on `tx`.
- Burst: push 8'h01..8'h05 back-to-back → serial output 01,02,03,04,05 in order, `tx_valid` continuously 1 across frames, `count` decrements at each `tx_ready`.
- Fill and overflow (DEPTH=16): hold `tx_ready=0` and push 18 words → `full=1` and `wr_ready=0` after 17 accepted (16 stored plus 1 in `hold`); the 18th is dropped and `overflow=1` stays set. Then drain → 17 correct words.
- Simultaneous push/pop: with `count=4`, push in the same cycle as `tx_ready` → `count` stays 4 and the order is preserved. Pointer wrap: stream 40 words through DEPTH=16 → all received in order.
- Spurious `tx_ready` in S_IDLE with the FIFO empty → no state change, `count` unchanged, `tx_valid` stays 0.
